wrra_weight_ctrl: RTL

- Generates the per-port and per-VC "weight consumed" flags consumed by the combined VC/switch allocator when it runs the weighted round-robin switch arbiter (WRRA).
- Tracks the switch grants each input port and each input VC receives against a per-port weight.
- Consumed flags demote a port or VC in the arbiter until a global refill.
- Sits in the router next to the allocator; it is the sequencing and configuration controller for the allocator's weight inputs.

---
 rtl/wrra_weight_ctrl_pkg.sv | 21 ++
 rtl/wrra_weight_ctrl_if.sv | 45 ++++
 rtl/wrra_weight_counter.sv | 45 ++++
 rtl/wrra_weight_ctrl.sv | 118 +++++++++++
 4 files changed

// File: rtl/wrra_weight_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module  : wrra_weight_ctrl_pkg
// Brief   : Shared constants, FSM encoding and weight normalise helper for WRRA.
// Revision: 1.0
// ============================================================================
package wrra_weight_ctrl_pkg;

    localparam int WEIGHTW_DEF = 4;
    localparam int NORM_W      = 16;

    localparam logic [0:0] ST_INIT = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    // A programmed weight of zero would starve the port forever, so treat it as one.
    function automatic logic [NORM_W-1:0] norm_weight(input logic [NORM_W-1:0] w);
        return (w == '0) ? NORM_W'(1) : w;
    endfunction

endpackage
`default_nettype wire

// File: rtl/wrra_weight_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module  : wrra_weight_ctrl_if
// Brief   : Allocator-side signal bundle of the WRRA weight controller.
//           WRRA_REFILL_CNT_EN adds the refill_cnt observation output.
// Revision: 1.0
// ============================================================================
interface wrra_weight_ctrl_if #(
    parameter int P       = 5,
    parameter int V       = 4,
    parameter int WEIGHTw = 4
);
    logic [P*WEIGHTw-1:0] iport_weight_all;
    logic [P*V-1:0]       ivc_request_all;
    logic [P*V-1:0]       ivc_num_getting_sw_grant;
    logic [P-1:0]         any_ivc_sw_request_granted_all;
    logic [P*V-1:0]       vc_weight_is_consumed_all;
    logic [P-1:0]         iport_weight_is_consumed_all;
`ifdef WRRA_REFILL_CNT_EN
    logic [15:0]          refill_cnt;

    modport master (
        output iport_weight_all, ivc_request_all, ivc_num_getting_sw_grant,
               any_ivc_sw_request_granted_all,
        input  vc_weight_is_consumed_all, iport_weight_is_consumed_all, refill_cnt
    );
    modport slave (
        input  iport_weight_all, ivc_request_all, ivc_num_getting_sw_grant,
               any_ivc_sw_request_granted_all,
        output vc_weight_is_consumed_all, iport_weight_is_consumed_all, refill_cnt
    );
`else
    modport master (
        output iport_weight_all, ivc_request_all, ivc_num_getting_sw_grant,
               any_ivc_sw_request_granted_all,
        input  vc_weight_is_consumed_all, iport_weight_is_consumed_all
    );
    modport slave (
        input  iport_weight_all, ivc_request_all, ivc_num_getting_sw_grant,
               any_ivc_sw_request_granted_all,
        output vc_weight_is_consumed_all, iport_weight_is_consumed_all
    );
`endif
endinterface
`default_nettype wire

// File: rtl/wrra_weight_counter.sv
`default_nettype none
// ============================================================================
// Module  : wrra_weight_counter
// Brief   : Saturating weight down-counter with load, load-minus-one and zero flag.
// Revision: 1.0
// ============================================================================
module wrra_weight_counter #(
    parameter int WEIGHTw = 4
) (
    input  wire logic               clk,
    input  wire logic               reset,
    input  wire logic               i_init,
    input  wire logic               i_refill,
    input  wire logic               i_dec,
    input  wire logic [WEIGHTw-1:0] i_weight,
    output logic                    o_zero
);

    logic [WEIGHTw-1:0] count_d;
    logic [WEIGHTw-1:0] count_q;

    // Weight is already normalised to >= 1, so weight minus a coincident grant never wraps.
    always_comb begin
        count_d = count_q;
        if (i_init) begin
            count_d = i_weight;
        end else if (i_refill) begin
            count_d = i_weight - WEIGHTw'(i_dec);
        end else if (i_dec && (count_q != '0)) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign o_zero = (count_q == '0);

endmodule
`default_nettype wire

// File: rtl/wrra_weight_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : wrra_weight_ctrl
// Brief   : Per-port / per-VC weight-consumed flag generator for the WRRA
//           switch arbiter. WRRA_REFILL_CNT_EN adds a 16-bit refill counter.
// Revision: 1.0
// ============================================================================
module wrra_weight_ctrl
    import wrra_weight_ctrl_pkg::*;
#(
    parameter int P       = 5,
    parameter int V       = 4,
    parameter int WEIGHTw = WEIGHTW_DEF
) (
    input  wire logic         clk,
    input  wire logic         reset,
    wrra_weight_ctrl_if.slave bus
);

    logic [0:0]         state_d;
    logic [0:0]         state_q;
    logic               init;
    logic               run;
    logic [WEIGHTw-1:0] w_norm [P];
    logic [P-1:0]       port_zero;
    logic [P*V-1:0]     vc_zero;
    logic [P-1:0]       port_req;
    logic               any_zero;
    logic               refill_blocked;
    logic               refill;

    assign init    = (state_q == ST_INIT);
    assign run     = (state_q == ST_RUN);
    assign state_d = ST_RUN;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_INIT;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        for (int p = 0; p < P; p++) begin
            w_norm[p] = WEIGHTw'(norm_weight(NORM_W'(bus.iport_weight_all[p*WEIGHTw +: WEIGHTw])));
        end
    end

    // A round ends once some port is spent and no port still holding weight wants service.
    always_comb begin
        any_zero       = 1'b0;
        refill_blocked = 1'b0;
        port_req       = '0;
        for (int p = 0; p < P; p++) begin
            port_req[p] = |bus.ivc_request_all[p*V +: V];
            if (port_zero[p]) begin
                any_zero = 1'b1;
            end else if (port_req[p]) begin
                refill_blocked = 1'b1;
            end
        end
        refill = run && any_zero && !refill_blocked;
    end

    generate
        for (genvar gp = 0; gp < P; gp++) begin : g_port
            wrra_weight_counter #(.WEIGHTw(WEIGHTw)) u_port_cnt (
                .clk      (clk),
                .reset    (reset),
                .i_init   (init),
                .i_refill (refill),
                .i_dec    (bus.any_ivc_sw_request_granted_all[gp]),
                .i_weight (w_norm[gp]),
                .o_zero   (port_zero[gp])
            );
            for (genvar gv = 0; gv < V; gv++) begin : g_vc
                wrra_weight_counter #(.WEIGHTw(WEIGHTw)) u_vc_cnt (
                    .clk      (clk),
                    .reset    (reset),
                    .i_init   (init),
                    .i_refill (refill),
                    .i_dec    (bus.ivc_num_getting_sw_grant[gp*V+gv]),
                    .i_weight (w_norm[gp]),
                    .o_zero   (vc_zero[gp*V+gv])
                );
            end
        end
    endgenerate

    // Counters are still zero while INIT loads them, so the flags are masked until RUN.
    assign bus.iport_weight_is_consumed_all = port_zero & {P{run}};
    assign bus.vc_weight_is_consumed_all    = vc_zero & {(P*V){run}};

`ifdef WRRA_REFILL_CNT_EN
    logic [15:0] refill_cnt_d;
    logic [15:0] refill_cnt_q;

    always_comb begin
        refill_cnt_d = refill_cnt_q;
        if (refill) begin
            refill_cnt_d = refill_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            refill_cnt_q <= '0;
        end else begin
            refill_cnt_q <= refill_cnt_d;
        end
    end

    assign bus.refill_cnt = refill_cnt_q;
`endif

endmodule
`default_nettype wire
